// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings, status flag bundle.
// Pure type definitions; no timing or flow-control behaviour of its own.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle ALU datapath (add/sub/logic/shift) with status flags.
// Latency: purely combinational. Backpressure: none, the caller registers the outputs.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;
  logic [WIDTH:0] add_w, sub_w, shl_w, shr_w;

  assign shamt = b[SW-1:0];

  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    // Extra bit beside the operand catches the last bit shifted out; stays 0 for shift of 0.
    shl_w = {1'b0, a} << shamt;
    shr_w = {a, 1'b0} >> shamt;
    res   = '0;
    flags = '0;
    case (op)
      OP_ADD: begin
        res         = add_w[WIDTH-1:0];
        flags.carry = add_w[WIDTH];
        flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res         = sub_w[WIDTH-1:0];
        flags.carry = sub_w[WIDTH];
        flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res         = shl_w[WIDTH-1:0];
        flags.carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        res         = shr_w[WIDTH:1];
        flags.carry = shr_w[0];
      end
      default: flags.err = 1'b1;  // MUL is not handled here
    endcase
    flags.zero = (res == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: ops 000-110 finish 1 cycle after accept, MUL (when ALU_SEQ_MUL_EN) WIDTH+1 cycles.
// Valid/ready both sides; one op in flight, result held until out_ready drains it.
// Without ALU_SEQ_MUL_EN, opcode 111 completes in one cycle with err=1 and no multiplier is built.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_e state, state_nxt;
  logic   accept;
  logic   is_mul;
  logic   mul_last;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  flags_t           flags_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a     (A),
    .b     (B),
    .op    (op_e'(sel)),
    .res   (core_res),
    .flags (core_flags)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      cnt;

  assign is_mul   = (sel == OP_MUL);
  assign mul_last = (cnt == CW'(WIDTH - 1));

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_nxt = {psum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (accept && is_mul) begin
      mcand <= A;
      prod  <= {{WIDTH{1'b0}}, B};
      cnt   <= '0;
    end else if (state == EXEC) begin
      prod  <= prod_nxt;
      cnt   <= cnt + CW'(1);
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = is_mul ? EXEC : DONE;
      EXEC:    if (mul_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      flags_q   <= '0;
    end else if (accept && !is_mul) begin
      result    <= core_res;
      result_hi <= '0;
      flags_q   <= core_flags;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state == EXEC && mul_last) begin
      result        <= prod_nxt[WIDTH-1:0];
      result_hi     <= prod_nxt[2*WIDTH-1:WIDTH];
      flags_q.carry <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
      flags_q.zero  <= (prod_nxt == '0);
      flags_q.ovf   <= 1'b0;
      flags_q.err   <= 1'b0;
    end
`endif
  end

  assign carry = flags_q.carry;
  assign zero  = flags_q.zero;
  assign ovf   = flags_q.ovf;
  assign err   = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result, result_hi;
  logic       carry, zero, ovf, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .ovf(ovf), .err(err)
  );

  // Presents one op, returns cycles from acceptance to out_valid (counting the accept edge), -1 on timeout.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, output int lat);
    @(negedge clk);
    A = a; B = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (result !== 8'h00 || result_hi !== 8'h00) begin n_fail++; $display("FAIL rst_result got %h/%h want 00/00", result_hi, result); end
    n_checks++; if ({carry, zero, ovf, err} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got %b want 0000", {carry, zero, ovf, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(8'hF0, 8'h20, 3'b000, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
    n_checks++; if (result !== 8'h10 || result_hi !== 8'h00) begin n_fail++; $display("FAIL add_result got %h/%h want 00/10", result_hi, result); end
    n_checks++; if ({carry, zero, ovf, err} !== 4'b1000) begin n_fail++; $display("FAIL add_flags got %b want 1000", {carry, zero, ovf, err}); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_done got %b want 0", in_ready); end
    drain();
  endtask

  task automatic test_sub();
    int lat;
    issue(8'h01, 8'h02, 3'b001, lat);
    n_checks++; if (result !== 8'hFF || {carry, zero, ovf, err} !== 4'b1000) begin n_fail++; $display("FAIL sub_borrow got %h %b want ff 1000", result, {carry, zero, ovf, err}); end
    drain();
    issue(8'h80, 8'h01, 3'b001, lat);
    n_checks++; if (result !== 8'h7F || {carry, zero, ovf, err} !== 4'b0010) begin n_fail++; $display("FAIL sub_ovf got %h %b want 7f 0010", result, {carry, zero, ovf, err}); end
    drain();
  endtask

  task automatic test_logic_shift();
    logic [7:0] va [8] = '{8'hCC, 8'hCC, 8'hCC, 8'h5A, 8'h81, 8'h81, 8'h81, 8'h80};
    logic [7:0] vb [8] = '{8'hAA, 8'hAA, 8'hAA, 8'h5A, 8'h01, 8'h08, 8'h01, 8'h07};
    logic [2:0] vs [8] = '{3'b010, 3'b011, 3'b100, 3'b100, 3'b101, 3'b101, 3'b110, 3'b110};
    logic [7:0] er [8] = '{8'h88, 8'hEE, 8'h66, 8'h00, 8'h02, 8'h81, 8'h40, 8'h01};
    logic [3:0] ef [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vs[i], lat);
      n_checks++;
      if (lat !== 1 || result !== er[i] || {carry, zero, ovf, err} !== ef[i] || result_hi !== 8'h00)
        begin n_fail++; $display("FAIL logic_shift[%0d] got lat=%0d %h %b want lat=1 %h %b", i, lat, result, {carry, zero, ovf, err}, er[i], ef[i]); end
      drain();
    end
  endtask

  task automatic test_mul();
    int lat;
    issue(8'hFF, 8'hFF, 3'b111, lat);
`ifdef ALU_SEQ_MUL_EN
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL mul_latency got %0d want 9", lat); end
    n_checks++; if (result !== 8'h01 || result_hi !== 8'hFE) begin n_fail++; $display("FAIL mul_product got %h%h want fe01", result_hi, result); end
    n_checks++; if ({carry, zero, ovf, err} !== 4'b1000) begin n_fail++; $display("FAIL mul_flags got %b want 1000", {carry, zero, ovf, err}); end
`else
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mul_latency got %0d want 1", lat); end
    n_checks++; if (result !== 8'h00 || result_hi !== 8'h00) begin n_fail++; $display("FAIL mul_product got %h%h want 0000", result_hi, result); end
    n_checks++; if ({carry, zero, ovf, err} !== 4'b0101) begin n_fail++; $display("FAIL mul_flags got %b want 0101", {carry, zero, ovf, err}); end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    issue(8'h01, 8'h01, 3'b000, lat);
    A = 8'h10; B = 8'h10; sel = 3'b001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 8'h02 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    drain();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    n_checks++; if (result !== 8'h02) begin n_fail++; $display("FAIL bp_ignored got %h want 02", result); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int rose = 0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; sel = 3'b111; in_valid = 1'b1;
`ifndef ALU_SEQ_MUL_EN
    // Single-cycle MUL here, so reset lands while the result sits in DONE.
    out_ready = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00) begin n_fail++; $display("FAIL midrst_clear got vld=%b %h%h want 0 0000", out_valid, result_hi, result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) rose++;
    end
    n_checks++; if (rose !== 0) begin n_fail++; $display("FAIL midrst_no_output got %0d valid cycles want 0", rose); end
    issue(8'h03, 8'h04, 3'b000, lat);
    n_checks++; if (lat !== 1 || result !== 8'h07) begin n_fail++; $display("FAIL midrst_next_add got lat=%0d %h want lat=1 07", lat, result); end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1 bit: an operation is presented.
REQ-005 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 Port A and port B, input, WIDTH bits each: unsigned operands.
REQ-007 Port sel, input, 3 bits: opcode; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 Port out_valid, output, 1 bit: a result is held.
REQ-009 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 Port result, output, WIDTH bits: low half of the result.
REQ-011 Port result_hi, output, WIDTH bits: high half of the MUL product; 0 for all other opcodes.
REQ-012 Port carry, zero, ovf and err, outputs, 1 bit each: status flags.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 An operation SHALL be accepted on an edge where in_valid and in_ready are both 1; A, B and sel are captured on that edge.
REQ-015 For opcodes 000-110, acceptance SHALL take the FSM IDLE->DONE with result and flags registered on that edge, so out_valid rises one cycle after acceptance.
REQ-016 For MUL, acceptance SHALL take the FSM IDLE->EXEC; one shift-add step runs per cycle for WIDTH cycles, then EXEC->DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 In DONE, the outputs SHALL hold stable until out_valid and out_ready are both 1 on an edge; that edge returns the FSM to IDLE.
REQ-018 in_valid SHALL be ignored outside IDLE; a new operation cannot be accepted on the same edge that a result is drained.
REQ-019 ADD SHALL set result=(A+B) mod 2^WIDTH, carry=carry-out, and ovf=signed two's-complement overflow.
REQ-020 SUB SHALL set result=(A-B) mod 2^WIDTH, carry=1 iff A<B (borrow), and ovf=signed overflow.
REQ-021 AND, OR and XOR SHALL be bitwise; for these opcodes carry=0 and ovf=0.
REQ-022 SHL and SHR SHALL be logical shifts of A by B[$clog2(WIDTH)-1:0]; carry is the last bit shifted out (0 for a shift of 0); ovf=0.
REQ-023 MUL SHALL set {result_hi,result}=A*B as an exact 2*WIDTH-bit product; carry=(result_hi!=0); ovf=0.
REQ-024 zero SHALL be 1 iff every produced result bit is 0 (for MUL, all 2*WIDTH bits).
REQ-025 err SHALL be 0 for every supported opcode.

Reset
REQ-026 While rst_n=0, regardless of clk, the FSM SHALL be in IDLE, and in_ready SHALL be 1 once reset is deasserted.
REQ-027 While rst_n=0, out_valid, result, result_hi, carry, zero, ovf and err SHALL all be 0.
REQ-028 Reset asserted during EXEC or DONE SHALL discard the operation with no output.

Configuration
REQ-029 The macro ALU_SEQ_MUL_EN SHALL control the multiplier; when defined, MUL and the EXEC state SHALL be implemented per REQ-016 and REQ-023.
REQ-030 When ALU_SEQ_MUL_EN is undefined, opcode 111 SHALL complete like a single-cycle op with result=0, result_hi=0, zero=1, carry=0, ovf=0 and err=1, and no multiplier logic SHALL be synthesised.

Structure
REQ-031 The package alu_pkg SHALL hold the opcode enum (3-bit) and the FSM state enum.
REQ-032 The single-cycle datapath (opcodes 000-110 plus flags) SHALL be the combinational sub-module alu_seq_core, instantiated once; the FSM and the multiplier stay in alu_seq.

Verification
REQ-033 The bench SHALL cover the following directed scenarios with WIDTH=8:
- Reset SHALL give all outputs 0 with in_ready=1.
- ADD with A=0xF0, B=0x20 -> result=0x10, carry=1, ovf=0, zero=0, out_valid one cycle after acceptance.
- SUB with A=0x01, B=0x02 -> result=0xFF, carry=1; SUB with A=0x80, B=0x01 -> result=0x7F, ovf=1.
- MUL with A=0xFF, B=0xFF -> result=0x01, result_hi=0xFE, carry=1, out_valid 9 cycles after acceptance; with ALU_SEQ_MUL_EN undefined, the same MUL -> err=1, result=0, 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles after ADD 0x01+0x01 -> result stays 0x02, in_ready stays 0, and a new in_valid is ignored; draining returns in_ready=1 the next cycle.
- rst_n pulsed low in cycle 4 of a MUL -> out_valid never rises for it, and the next ADD 0x03+0x04 -> result=0x07.
